// File: rtl/twiddle_mul.sv
// Four-lane complex twiddle multiplier, fixed 3-cycle pipeline (products, sums, round/narrow).
// Define TWMUL_SAT_EN to saturate the 16-bit narrowing; otherwise results wrap.
module twiddle_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        R4_valid,
  input  logic        R2_valid,
  input  logic        factor,
  input  logic [31:0] W0,
  input  logic [31:0] W1,
  input  logic [31:0] W2,
  input  logic [31:0] W3,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic [31:0] d3,
  output logic [31:0] q0,
  output logic [31:0] q1,
  output logic [31:0] q2,
  output logic [31:0] q3,
  output logic        q_valid,
  output logic        q_r4
);

  localparam logic [31:0] W_ONE = 32'h4000_0000;

  logic [3:0][31:0] d_in;
  logic [3:0][31:0] w_sel;

  // S1: partial products and beat tags
  logic signed [31:0] ac_d [4];
  logic signed [31:0] bs_d [4];
  logic signed [31:0] as_d [4];
  logic signed [31:0] bc_d [4];
  logic signed [31:0] ac_q [4];
  logic signed [31:0] bs_q [4];
  logic signed [31:0] as_q [4];
  logic signed [31:0] bc_q [4];
  logic               v1_d, r4_1_d, f1_d;
  logic               v1_q, r4_1_q, f1_q;

  // S2: 33-bit sums
  logic signed [32:0] re_d [4];
  logic signed [32:0] im_d [4];
  logic signed [32:0] re_q [4];
  logic signed [32:0] im_q [4];
  logic               v2_d, r4_2_d, f2_d;
  logic               v2_q, r4_2_q, f2_q;

  // S3: rounded, narrowed outputs
  logic [3:0][31:0]   q_d;
  logic [3:0][31:0]   q_q;
  logic               q_valid_d, q_valid_q;
  logic               q_r4_d, q_r4_q;

  function automatic logic [15:0] round_narrow(input logic signed [32:0] sum,
                                               input logic              half);
    logic signed [33:0] biased;
`ifdef TWMUL_SAT_EN
    logic signed [19:0] shifted;
    biased  = {sum[32], sum} + (half ? 34'sd16384 : 34'sd8192);
    shifted = half ? 20'(biased >>> 15) : 20'(biased >>> 14);
    if (shifted > 20'sd32767) begin
      round_narrow = 16'h7fff;
    end else if (shifted < -20'sd32768) begin
      round_narrow = 16'h8000;
    end else begin
      round_narrow = shifted[15:0];
    end
`else
    biased       = {sum[32], sum} + (half ? 34'sd16384 : 34'sd8192);
    round_narrow = half ? 16'(biased >>> 15) : 16'(biased >>> 14);
`endif
  endfunction

  // A zero twiddle on R2 lanes 2/3 yields zero products, which round to exactly 0.
  always_comb begin
    d_in     = {d3, d2, d1, d0};
    w_sel[0] = W_ONE;
    if (R4_valid) begin
      w_sel[1] = W0;
      w_sel[2] = W1;
      w_sel[3] = W2;
    end else begin
      w_sel[1] = W3;
      w_sel[2] = 32'h0;
      w_sel[3] = 32'h0;
    end
    for (int i = 0; i < 4; i++) begin
      ac_d[i] = $signed(d_in[i][31:16]) * $signed(w_sel[i][31:16]);
      bs_d[i] = $signed(d_in[i][15:0])  * $signed(w_sel[i][15:0]);
      as_d[i] = $signed(d_in[i][31:16]) * $signed(w_sel[i][15:0]);
      bc_d[i] = $signed(d_in[i][15:0])  * $signed(w_sel[i][31:16]);
    end
    v1_d   = R4_valid | R2_valid;
    r4_1_d = R4_valid;
    f1_d   = factor;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      re_d[i] = {ac_q[i][31], ac_q[i]} - {bs_q[i][31], bs_q[i]};
      im_d[i] = {as_q[i][31], as_q[i]} + {bc_q[i][31], bc_q[i]};
    end
    v2_d   = v1_q;
    r4_2_d = r4_1_q;
    f2_d   = f1_q;
  end

  // Outputs only update on a valid beat, so bubbles leave the last result visible.
  always_comb begin
    q_d       = q_q;
    q_r4_d    = q_r4_q;
    q_valid_d = v2_q;
    if (v2_q) begin
      for (int i = 0; i < 4; i++) begin
        q_d[i] = {round_narrow(re_q[i], f2_q), round_narrow(im_q[i], f2_q)};
      end
      q_r4_d = r4_2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        ac_q[i] <= '0;
        bs_q[i] <= '0;
        as_q[i] <= '0;
        bc_q[i] <= '0;
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
      v1_q      <= 1'b0;
      r4_1_q    <= 1'b0;
      f1_q      <= 1'b0;
      v2_q      <= 1'b0;
      r4_2_q    <= 1'b0;
      f2_q      <= 1'b0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      q_r4_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        ac_q[i] <= ac_d[i];
        bs_q[i] <= bs_d[i];
        as_q[i] <= as_d[i];
        bc_q[i] <= bc_d[i];
        re_q[i] <= re_d[i];
        im_q[i] <= im_d[i];
      end
      v1_q      <= v1_d;
      r4_1_q    <= r4_1_d;
      f1_q      <= f1_d;
      v2_q      <= v2_d;
      r4_2_q    <= r4_2_d;
      f2_q      <= f2_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      q_r4_q    <= q_r4_d;
    end
  end

  assign q0      = q_q[0];
  assign q1      = q_q[1];
  assign q2      = q_q[2];
  assign q3      = q_q[3];
  assign q_valid = q_valid_q;
  assign q_r4    = q_r4_q;

endmodule

// File: tb/tb_twiddle_mul.sv
// Directed + random stimulus for twiddle_mul; expected beats queued at drive time, checked on q_valid.
module tb_twiddle_mul;

  localparam logic [31:0] W_ONE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        R4_valid = 1'b0, R2_valid = 1'b0, factor = 1'b0;
  logic [31:0] W0 = '0, W1 = '0, W2 = '0, W3 = '0;
  logic [31:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [31:0] q0, q1, q2, q3;
  logic        q_valid, q_r4;

  typedef struct {
    logic [3:0][31:0] q;
    logic             r4;
    int               due;
  } exp_t;

  exp_t             sb[$];
  logic [3:0][31:0] last_q = '0;
  logic             last_r4 = 1'b0;
  int               cyc = 0;
  int               errors = 0;
  int               checks = 0;

  twiddle_mul u_dut (
    .clk(clk), .rst_n(rst_n),
    .R4_valid(R4_valid), .R2_valid(R2_valid), .factor(factor),
    .W0(W0), .W1(W1), .W2(W2), .W3(W3),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .q_valid(q_valid), .q_r4(q_r4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] narrow(input longint v, input bit f);
    longint r;
    r = f ? ((v + 16384) >>> 15) : ((v + 8192) >>> 14);
`ifdef TWMUL_SAT_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  function automatic logic [31:0] lane(input logic [31:0] d, input logic [31:0] w, input bit f);
    longint a, b, c, s;
    a = longint'($signed(d[31:16]));
    b = longint'($signed(d[15:0]));
    c = longint'($signed(w[31:16]));
    s = longint'($signed(w[15:0]));
    return {narrow(a * c - b * s, f), narrow(a * s + b * c, f)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input bit r4v, input bit r2v, input bit f,
                      input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3,
                      input logic [31:0] x0, input logic [31:0] x1,
                      input logic [31:0] x2, input logic [31:0] x3);
    exp_t e;
    @(negedge clk);
    R4_valid = r4v; R2_valid = r2v; factor = f;
    W0 = w0; W1 = w1; W2 = w2; W3 = w3;
    d0 = x0; d1 = x1; d2 = x2; d3 = x3;
    if (r4v || r2v) begin
      e.q[0] = lane(x0, W_ONE, f);
      e.q[1] = lane(x1, r4v ? w0 : w3, f);
      e.q[2] = r4v ? lane(x2, w1, f) : 32'h0;
      e.q[3] = r4v ? lane(x3, w2, f) : 32'h0;
      e.r4   = r4v;
      e.due  = cyc + 3;
      sb.push_back(e);
    end
  endtask

  task automatic bubble();
    beat(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom());
  endtask

  // Output monitor: pops the scoreboard on q_valid, otherwise checks that outputs hold.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (q_valid === 1'b1) begin
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_q_valid observed=1 expected=0");
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("latency", 32'(cyc), 32'(e.due));
          chk("q0", q0, e.q[0]);
          chk("q1", q1, e.q[1]);
          chk("q2", q2, e.q[2]);
          chk("q3", q3, e.q[3]);
          chk("q_r4", {31'b0, q_r4}, {31'b0, e.r4});
          last_q  = e.q;
          last_r4 = e.r4;
        end
      end else begin
        chk("hold_q", {q3, q2, q1, q0} == last_q ? 32'd1 : 32'd0, 32'd1);
        chk("hold_r4", {31'b0, q_r4}, {31'b0, last_r4});
      end
    end
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_q0", q0, 32'h0);
    chk("rst_q1", q1, 32'h0);
    chk("rst_q2", q2, 32'h0);
    chk("rst_q3", q3, 32'h0);
    chk("rst_q_valid", {31'b0, q_valid}, 32'h0);
    chk("rst_q_r4", {31'b0, q_r4}, 32'h0);
    rst_n = 1'b1;
    repeat (3) bubble();

    // R4 beat with -j, 1, -1
    beat(1, 0, 0, 32'h0000_C000, 32'h4000_0000, 32'hC000_0000, 32'h1234_5678,
         {16'sd1000, 16'sd2000}, {16'sd1000, 16'sd2000}, {16'sd1000, 16'sd2000}, {16'sd1000, 16'sd2000});
    // R2 beat with e^-j*pi/4, junk on unused twiddles and lanes
    beat(0, 1, 0, 32'h7654_3210, 32'h1111_2222, 32'h3333_4444, 32'h2D41_D2BF,
         {16'sd1000, 16'sd2000}, {16'sd16384, 16'sd0}, {16'sd1234, -16'sd5678}, {-16'sd321, 16'sd77});
    // scaling by 1/2
    beat(1, 0, 1, 32'h0000_C000, 32'h4000_0000, 32'hC000_0000, 32'h0,
         {16'sd1000, 16'sd2000}, {16'sd1000, 16'sd2000}, {16'sd1000, 16'sd2000}, {16'sd1000, 16'sd2000});
    // out-of-range im
    beat(1, 0, 0, 32'h4000_4000, 32'h4000_0000, 32'h4000_0000, 32'h0,
         32'h0001_0001, 32'h8000_8000, 32'h7fff_7fff, 32'h8000_7fff);
    repeat (4) bubble();

    // streaming: R4, bubble, R2, R4, then both valids
    beat(1, 0, 0, $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom());
    bubble();
    beat(0, 1, 1, $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom());
    beat(1, 0, 1, $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom());
    beat(1, 1, 0, $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom());
    repeat (4) bubble();

    for (int i = 0; i < 24; i++) begin
      beat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom());
    end

    // reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      beat(1, 0, 0, $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom());
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0; R4_valid = 1'b0; R2_valid = 1'b0;
    #1;
    chk("midrst_q0", q0, 32'h0);
    chk("midrst_q1", q1, 32'h0);
    chk("midrst_q2", q2, 32'h0);
    chk("midrst_q3", q3, 32'h0);
    chk("midrst_q_valid", {31'b0, q_valid}, 32'h0);
    chk("midrst_q_r4", {31'b0, q_r4}, 32'h0);
    sb.delete();
    last_q  = '0;
    last_r4 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) bubble();
    beat(0, 1, 0, $urandom(), $urandom(), $urandom(), 32'h2D41_D2BF,
         $urandom(), {16'sd16384, 16'sd0}, $urandom(), $urandom());
    repeat (6) bubble();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain observed=%0d expected=0 pending beats", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/twiddle_mul.md
# twiddle_mul

Four-lane complex twiddle multiplier sitting directly downstream of the twiddle-factor generator in the FFT2048 datapath. It consumes the generator's registered W0..W3, R4_valid/R2_valid and factor, together with the butterfly outputs of the current stage, and applies the per-lane twiddle rotation. It also applies the optional 1/2 stage scaling and delivers rounded 16-bit complex results to the next stage's butterfly through a fixed 3-cycle pipeline.

## Interface
- No parameters.
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- R4_valid  in  1  radix-4 beat; W0..W2 and d0..d3 are valid this cycle.
- R2_valid  in  1  radix-2 beat; W3, d0 and d1 are valid this cycle.
- factor  in  1  scale this beat's results by 1/2.
- W0, W1, W2, W3  in  32 each  twiddles, {re[31:16], im[15:0]}, signed Q2.14 (1.0 = 16384). W0 = W^p, W1 = W^2p, W2 = W^3p, W3 = radix-2 W^p.
- d0, d1, d2, d3  in  32 each  butterfly outputs, {re, im}, signed 16-bit integers.
- q0, q1, q2, q3  out  32 each  twiddled results, {re, im}, signed 16-bit.
- q_valid  out  1  q0..q3 valid.
- q_r4  out  1  1 if the q_valid beat was radix-4, 0 if radix-2.

## Operation
- Lane twiddle selection:
  - R4 beat: lane0 uses 1.0 (0x4000_0000); lane1 uses W0; lane2 uses W1; lane3 uses W2.
  - R2 beat: lane0 uses 1.0; lane1 uses W3; lanes 2 and 3 force their output to 0.
- Pass-through lanes go through the same multiplier path with W = 1.0. Latency and rounding are therefore identical on all lanes.
- Arithmetic per lane, for d = (a, b) and W = (c, s):
  - re = a*c - b*s, im = a*s + b*c.
  - Products are 32-bit signed; sums are 33-bit signed.
- Rounding:
  - factor = 0: result = (sum + 2^13) >>> 14.
  - factor = 1: result = (sum + 2^14) >>> 15.
  - Round-half-up, arithmetic shift.
- Narrowing to 16 bits: saturate to [-32768, 32767] when TWMUL_SAT_EN is defined, otherwise truncate (wrap).
- R4_valid and R2_valid both high in the same cycle: treated as an R4 beat. The upstream generator never drives both.
- Neither valid: the beat is a bubble. Bubbles propagate as q_valid = 0, and q0..q3 and q_r4 hold their last values.
- No backpressure: one beat is accepted every cycle. factor and the mode flag travel down the pipeline with their beat.

## Timing
- Beat presented at cycle N (valid, W, d, factor all sampled together) produces q_valid = 1 with its result at cycle N+3.
- Pipeline stages:
  - S1 registers the 4 partial products per lane plus the mode and factor tags.
  - S2 registers the 33-bit sums.
  - S3 registers the rounded, narrowed outputs.
- Back-to-back beats give back-to-back q_valid with no gaps. Mixed R4/R2 sequences keep their order and their per-beat tags.
- Reset values: q0..q3 = 0, q_valid = 0, q_r4 = 0, all internal stage registers and valid tags = 0.
- Reset asserted mid-stream discards all in-flight beats. The first q_valid after reset release comes 3 cycles after the first valid input.

## Configuration
- TWMUL_SAT_EN defined: out-of-range results clamp to 32767 / -32768.
- TWMUL_SAT_EN not defined: the low 16 bits of the shifted result are kept (two's-complement wrap). Saves the compare logic; legal when upstream scaling guarantees headroom.

## Test plan
- R4 beat:
  - Stimulus: W0 = 0x0000_C000 (-j), W1 = 0x4000_0000, W2 = 0xC000_0000 (-1), d0..d3 = (1000, 2000), factor = 0.
  - Required at N+3: q0 = (1000, 2000), q1 = (2000, -1000), q2 = (1000, 2000), q3 = (-1000, -2000), q_valid = 1, q_r4 = 1.
- R2 beat:
  - Stimulus: W3 = 0x2D41_D2BF (≈ e^-jπ/4), d1 = (16384, 0), d2 and d3 nonzero.
  - Required: q1 = (11585, -11585), q2 = q3 = 0, q_r4 = 0.
- Scaling: same as the R4 case with factor = 1 -> q1 = (1000, -500), q0 = (500, 1000).
- Saturation:
  - Stimulus: d1 = (-32768, -32768), W0 = 0x4000_4000 (1 + j).
  - Required: im saturates to -32768 and re = 0 with TWMUL_SAT_EN defined; im wraps to 0 without it.
- Streaming and bubbles: alternate R4, bubble, R2, R4 on consecutive cycles -> the q_valid pattern 1,0,1,1 appears delayed by 3, tags are correct, and outputs hold during the bubble.
- Reset: assert rst_n low while 3 beats are in flight -> all outputs read 0 immediately, and no q_valid appears after release until 3 cycles after a new valid input.
